rd_return_collector: RTL and testbench

- Return-path counterpart of the instruction dispatcher.
- Records each read command the dispatcher issues as a tag: host read or periodic read.
- Matches PHY read-data returns to those tags in issue order.
- Routes host-read beats to a buffered valid/ready stream toward the host interface, and periodic-read beats to a non-blocking pulse interface.
- Sits between the DFI read-data path and the host return FIFO / periodic-read logic.

---
 rtl/rd_return_collector.sv | 253 +++++++++++++++++++++++++
 tb/tb_rd_return_collector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_return_collector.sv
// rd_return_collector: read-return path of the instruction dispatcher.
// Each issued read command leaves a one-bit tag (1 = periodic, 0 = host) in
// an in-order tag FIFO. PHY read beats are matched to the head tag. Host
// beats go to a first-word-fall-through output FIFO with a valid/ready
// handshake. Periodic beats leave as a one-cycle registered strobe.
// The PHY is never backpressured: anything that cannot be stored is dropped
// and recorded in the sticky err_flags.
//
// Optional feature macro: RD_TIMEOUT_EN
//   defined   -> a watchdog retires a stalled head read after TIMEOUT_CYCLES
//   undefined -> reads wait indefinitely; err_flags[3] is constant 0
module rd_return_collector #(
    parameter int DATA_WIDTH     = 256,
    parameter int BEATS_PER_READ = 2,
    parameter int TAG_DEPTH      = 16,
    parameter int OUT_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_issue,
    input  logic                         rd_issue_periodic,
    input  logic                         dfi_rddata_valid,
    input  logic [DATA_WIDTH-1:0]        dfi_rddata,
    output logic                         host_valid,
    input  logic                         host_ready,
    output logic [DATA_WIDTH-1:0]        host_data,
    output logic                         host_last,
    output logic                         pr_valid,
    output logic [DATA_WIDTH-1:0]        pr_data,
    output logic                         pr_last,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic [3:0]                   err_flags
);

    localparam int TAW = $clog2(TAG_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int BCW = (BEATS_PER_READ > 1) ? $clog2(BEATS_PER_READ) : 1;

    localparam logic [BCW-1:0] LAST_BEAT    = BCW'(BEATS_PER_READ - 1);
    localparam logic [TAW:0]   TAG_FULL_CNT = (TAW+1)'(TAG_DEPTH);
    localparam logic [OAW:0]   OUT_FULL_CNT = (OAW+1)'(OUT_DEPTH);

    // Matcher states
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    // ------------------------------------------------------------------
    // Tag FIFO storage and control
    // ------------------------------------------------------------------
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [TAW-1:0]       tag_wptr;
    logic [TAW-1:0]       tag_rptr;
    logic [TAW:0]         tag_cnt;
    logic                 tag_empty;
    logic                 tag_full;
    logic                 head_tag;
    logic                 tag_push;
    logic                 tag_pop;
    logic                 tag_ovf;

    // ------------------------------------------------------------------
    // Matcher
    // ------------------------------------------------------------------
    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [BCW-1:0]       beat_cnt;
    logic                 beat_acc;
    logic                 beat_last;
    logic                 beat_pop;
    logic                 orphan;
    logic                 timeout_pop;

    // ------------------------------------------------------------------
    // Host output FIFO (data + last flag per entry)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]  of_mem [OUT_DEPTH];
    logic [OAW-1:0]       of_wptr;
    logic [OAW-1:0]       of_rptr;
    logic [OAW:0]         of_cnt;
    logic                 of_full;
    logic                 of_wr;
    logic                 of_rd;
    logic                 of_push;
    logic                 of_ovf;

    // Head-of-queue status; a tag pushed this cycle only shows up next cycle
    always_comb begin
        tag_empty = (tag_cnt == '0);
        tag_full  = (tag_cnt == TAG_FULL_CNT);
        head_tag  = tag_mem[tag_rptr];
    end

    // Beat classification and tag FIFO push/pop decisions
    always_comb begin
        beat_acc  = dfi_rddata_valid & ~tag_empty;
        orphan    = dfi_rddata_valid &  tag_empty;
        beat_last = (beat_cnt == LAST_BEAT);
        beat_pop  = beat_acc & beat_last;
        tag_pop   = beat_pop | timeout_pop;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        tag_push  = rd_issue & (~tag_full | tag_pop);
        tag_ovf   = rd_issue &   tag_full & ~tag_pop;
    end

    // Tag FIFO pointers, occupancy and storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem  <= '0;
            tag_wptr <= '0;
            tag_rptr <= '0;
            tag_cnt  <= '0;
        end else begin
            if (tag_push) begin
                tag_mem[tag_wptr] <= rd_issue_periodic;
                tag_wptr          <= tag_wptr + 1'b1;
            end
            if (tag_pop) begin
                tag_rptr <= tag_rptr + 1'b1;
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    assign outstanding = tag_cnt;

`ifdef RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wd_cnt;

    // Watchdog fires when the head read has made no progress for the limit
    always_comb begin
        timeout_pop = ~tag_empty & ~beat_acc & (wd_cnt == WD_LIMIT);
    end

    // Watchdog counts idle cycles with reads outstanding, restarts on progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (tag_empty || beat_acc || tag_pop) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout_pop = 1'b0;
`endif

    // Matcher next state: leave IDLE on a non-final first beat, return on pop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat_acc && !beat_last) state_nxt = COLLECT;
            COLLECT: if (tag_pop)                state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Matcher state and beat position within the current read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (tag_pop) begin
                beat_cnt <= '0;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Periodic beats: one registered strobe per beat, no storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_valid <= 1'b0;
            pr_data  <= '0;
            pr_last  <= 1'b0;
        end else begin
            pr_valid <= beat_acc & head_tag;
            pr_last  <= beat_acc & head_tag & beat_last;
            if (beat_acc && head_tag) begin
                pr_data <= dfi_rddata;
            end
        end
    end

    // Host FIFO write/read decisions; overflow drops the beat but not framing
    always_comb begin
        of_full = (of_cnt == OUT_FULL_CNT);
        of_wr   = beat_acc & ~head_tag;
        of_rd   = host_valid & host_ready;
        of_push = of_wr & (~of_full | of_rd);
        of_ovf  = of_wr &   of_full & ~of_rd;
    end

    // Host FIFO storage (data path only, no reset needed)
    always_ff @(posedge clk) begin
        if (of_push) begin
            of_mem[of_wptr] <= {beat_last, dfi_rddata};
        end
    end

    // Host FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_wptr <= '0;
            of_rptr <= '0;
            of_cnt  <= '0;
        end else begin
            if (of_push) begin
                of_wptr <= of_wptr + 1'b1;
            end
            if (of_rd) begin
                of_rptr <= of_rptr + 1'b1;
            end
            case ({of_push, of_rd})
                2'b10:   of_cnt <= of_cnt + 1'b1;
                2'b01:   of_cnt <= of_cnt - 1'b1;
                default: of_cnt <= of_cnt;
            endcase
        end
    end

    // First-word-fall-through view; outputs forced to 0 while empty
    always_comb begin
        host_valid = (of_cnt != '0);
        host_data  = '0;
        host_last  = 1'b0;
        if (host_valid) begin
            host_data = of_mem[of_rptr][DATA_WIDTH-1:0];
            host_last = of_mem[of_rptr][DATA_WIDTH];
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= '0;
        end else begin
            err_flags <= err_flags | {timeout_pop, of_ovf, orphan, tag_ovf};
        end
    end

endmodule

// File: tb/tb_rd_return_collector.sv
// Scoreboard bench for rd_return_collector (default parameters, feature off).
// A negedge reference model tracks outstanding reads as a queue of tags and
// pushes expected host / periodic beats; a monitor pops and compares them
// whenever the DUT presents a beat.
module tb_rd_return_collector;

    localparam int DW  = 256;
    localparam int BPR = 2;
    localparam int TD  = 16;
    localparam int OD  = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int unsigned   st;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_issue = 1'b0;
    logic          rd_issue_periodic = 1'b0;
    logic          dfi_rddata_valid = 1'b0;
    logic [DW-1:0] dfi_rddata = '0;
    logic          host_ready = 1'b0;
    logic          host_valid;
    logic [DW-1:0] host_data;
    logic          host_last;
    logic          pr_valid;
    logic [DW-1:0] pr_data;
    logic          pr_last;
    logic [4:0]    outstanding;
    logic [3:0]    err_flags;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    // reference model state
    bit          tq[$];
    ent_t        hq[$];
    ent_t        pq[$];
    int          occ   = 0;
    int          bi    = 0;
    logic [3:0]  err_m = '0;

    rd_return_collector #(
        .DATA_WIDTH(DW),
        .BEATS_PER_READ(BPR),
        .TAG_DEPTH(TD),
        .OUT_DEPTH(OD),
        .TIMEOUT_CYCLES(1023)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd_issue(rd_issue),
        .rd_issue_periodic(rd_issue_periodic),
        .dfi_rddata_valid(dfi_rddata_valid),
        .dfi_rddata(dfi_rddata),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_data(host_data),
        .host_last(host_last),
        .pr_valid(pr_valid),
        .pr_data(pr_data),
        .pr_last(pr_last),
        .outstanding(outstanding),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step(input logic iss, input logic per, input logic v, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        rd_issue          = iss;
        rd_issue_periodic = per;
        dfi_rddata_valid  = v;
        dfi_rddata        = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_host_valid"}, host_valid, 1'b0);
        chk({tag, "_host_data"},  host_data,  '0);
        chk({tag, "_host_last"},  host_last,  1'b0);
        chk({tag, "_pr_valid"},   pr_valid,   1'b0);
        chk({tag, "_pr_data"},    pr_data,    '0);
        chk({tag, "_pr_last"},    pr_last,    1'b0);
        chk({tag, "_outstanding"}, outstanding, '0);
        chk({tag, "_err_flags"},  err_flags,  '0);
    endtask

    // Reference model: decides, from the inputs that the coming posedge will
    // sample, what the collector must do with each issue and each beat.
    always @(negedge clk) begin
        bit   hpop;
        bit   last;
        ent_t e;
        if (!rst_n) begin
            tq.delete();
            hq.delete();
            pq.delete();
            occ   = 0;
            bi    = 0;
            err_m = '0;
        end else begin
            chk("outstanding", outstanding, tq.size());
            chk("err_flags",   err_flags,   err_m);
            chk("host_valid",  host_valid,  occ != 0);
            hpop = (occ != 0) && host_ready;
            if (dfi_rddata_valid) begin
                if (tq.size() == 0) begin
                    err_m[1] = 1'b1;
                end else begin
                    last = (bi == BPR - 1);
                    e.d  = dfi_rddata;
                    e.l  = last;
                    e.st = cyc + 1;
                    if (tq[0]) begin
                        pq.push_back(e);
                    end else if (occ == OD && !hpop) begin
                        err_m[2] = 1'b1;
                    end else begin
                        hq.push_back(e);
                        occ++;
                    end
                    if (last) begin
                        void'(tq.pop_front());
                        bi = 0;
                    end else begin
                        bi++;
                    end
                end
            end
            if (hpop) occ--;
            if (rd_issue) begin
                if (tq.size() < TD) tq.push_back(rd_issue_periodic);
                else err_m[0] = 1'b1;
            end
        end
    end

    // Monitor: compares every beat the DUT presents against the scoreboard
    always @(negedge clk) begin
        ent_t e;
        if (rst_n) begin
            if (host_valid && host_ready) begin
                if (hq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL host_unexpected: got beat %0h expected none", host_data);
                end else begin
                    e = hq.pop_front();
                    chk("host_data", host_data, e.d);
                    chk("host_last", host_last, e.l);
                end
            end
            if (pr_valid) begin
                if (pq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pr_unexpected: got beat %0h expected none", pr_data);
                end else begin
                    e = pq.pop_front();
                    chk("pr_data",  pr_data, e.d);
                    chk("pr_last",  pr_last, e.l);
                    chk("pr_cycle", cyc,     e.st);
                end
            end else if (pq.size() != 0 && pq[0].st < cyc) begin
                e = pq.pop_front();
                tests++;
                fails++;
                $display("FAIL pr_missing: got no strobe expected beat %0h at cycle %0d", e.d, e.st);
            end
        end
    end

    initial begin
        int guard;
        host_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // three host reads, ready always high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
        idle(2);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, DW'(8'hA0 + i));
        idle(4);
        chk("host_done_outstanding", outstanding, '0);

        // host, periodic, host
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        idle(2);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, DW'(8'hB0 + i));
        idle(4);
        chk("mixed_err_clean", err_flags, '0);

        // backpressure: 10 host beats into an 8-deep buffer
        host_ready = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
        idle(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, DW'(8'hD0 + i));
        idle(3);
        chk("bp_overflow_flag", err_flags[2], 1'b1);
        chk("bp_held", hq.size(), OD);
        host_ready = 1'b1;
        idle(12);
        chk("bp_drained", hq.size(), 0);

        // orphan beat, then issue and beat in the same cycle from empty
        step(1'b0, 1'b0, 1'b1, DW'(8'hC0));
        idle(2);
        chk("orphan_flag", err_flags[1], 1'b1);
        step(1'b1, 1'b0, 1'b1, DW'(8'hC1));
        idle(2);
        chk("simul_outstanding", outstanding, 5'd1);
        step(1'b0, 1'b0, 1'b1, DW'(8'hC2));
        step(1'b0, 1'b0, 1'b1, DW'(8'hC3));
        idle(3);

        // tag overflow, then issue together with a final beat while full
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, '0);
        idle(2);
        chk("tag_full_outstanding", outstanding, 5'd16);
        chk("tag_ovf_flag", err_flags[0], 1'b1);
        step(1'b0, 1'b0, 1'b1, rnd_data());
        step(1'b1, 1'b1, 1'b1, rnd_data());
        idle(1);
        chk("full_swap_outstanding", outstanding, 5'd16);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, rnd_data());
        idle(4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) == 0), $urandom_range(1), ($urandom_range(1) == 0), rnd_data());
            host_ready = $urandom_range(1);
        end
        host_ready = 1'b1;
        guard = 0;
        while (tq.size() != 0 && guard < 200) begin
            step(1'b0, 1'b0, 1'b1, rnd_data());
            guard++;
        end
        idle(12);
        chk("random_tags_done", tq.size(), 0);

        // reset in the middle of a host read, then a clean read
        step(1'b1, 1'b0, 1'b0, '0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, DW'(8'hE0));
        idle(2);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, DW'(8'hF0));
        step(1'b0, 1'b0, 1'b1, DW'(8'hF1));
        idle(1);

        guard = 0;
        while ((hq.size() != 0 || pq.size() != 0) && guard < 100) begin
            idle(1);
            guard++;
        end
        chk("final_host_queue", hq.size(), 0);
        chk("final_pr_queue",   pq.size(), 0);
        chk("final_err_clean",  err_flags, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
